// File: rtl/mac_vec_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_vec_pipe_if : operand/control and result bundle for mac_vec_pipe |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mac_vec_pipe_if #(
  parameter int LANES = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 32
);
  logic                   in_valid;
  logic [LANES*A_W-1:0]   a;
  logic [LANES*B_W-1:0]   b;
  logic                   mode;
  logic                   sat_en;
  logic                   last;
  logic                   clr;
  logic [LANES*ACC_W-1:0] acc;
  logic [LANES*ACC_W-1:0] res;
  logic [LANES-1:0]       res_ovf;
  logic                   res_valid;

  modport master (
    output in_valid, a, b, mode, sat_en, last, clr,
    input  acc, res, res_ovf, res_valid
  );

  modport slave (
    input  in_valid, a, b, mode, sat_en, last, clr,
    output acc, res, res_ovf, res_valid
  );
endinterface
`default_nettype wire

// File: rtl/mac_vec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_vec_pipe : LANES-wide two-stage signed MAC / residual accumulator |
// | with optional saturation, sticky overflow and last-beat snapshot.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mac_vec_pipe #(
  parameter int LANES              = 4,
  parameter int A_W                = 8,
  parameter int B_W                = 8,
  parameter int ACC_W              = 32,
  parameter int ENABLE_ZERO_BYPASS = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mac_vec_pipe_if.slave      bus
);

  localparam int P_W = A_W + B_W;

  if (ACC_W < A_W + B_W + 1) begin : g_acc_w_check
    $error("mac_vec_pipe: ACC_W must be at least A_W+B_W+1");
  end

  logic r_s1_valid;
  logic r_s1_mode;
  logic r_s1_sat;
  logic r_s1_last;
  logic r_res_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_sat    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_s1_valid  <= bus.in_valid & ~bus.clr;
      r_s1_mode   <= bus.mode;
      r_s1_sat    <= bus.sat_en;
      r_s1_last   <= bus.last;
      r_res_valid <= r_s1_valid & r_s1_last & ~bus.clr;
    end
  end

  assign bus.res_valid = r_res_valid;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [A_W-1:0]   w_a;
    logic signed [B_W-1:0]   w_b;
    logic                    w_gate;
    logic signed [A_W-1:0]   w_ag;
    logic signed [B_W-1:0]   w_bg;
    logic signed [P_W-1:0]   w_mul;
    logic signed [P_W-1:0]   r_prod;
    logic signed [A_W-1:0]   r_a;
    logic [ACC_W-1:0]        w_addend;
    logic [ACC_W:0]          w_sum;
    logic                    w_ovf;
    logic [ACC_W-1:0]        w_store;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        r_res;
    logic                    r_ovf;
    logic                    r_rovf;

    assign w_a    = bus.a[g*A_W +: A_W];
    assign w_b    = bus.b[g*B_W +: B_W];
    // Residual mode never uses the multiplier, so its inputs are parked at 0.
    assign w_gate = bus.mode | ((ENABLE_ZERO_BYPASS != 0) & ((w_a == '0) | (w_b == '0)));
    assign w_ag   = w_gate ? '0 : w_a;
    assign w_bg   = w_gate ? '0 : w_b;
    assign w_mul  = w_ag * w_bg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prod <= '0;
        r_a    <= '0;
      end else begin
        r_prod <= w_mul;
        r_a    <= w_a;
      end
    end

    assign w_addend = r_s1_mode ? {{(ACC_W-A_W){r_a[A_W-1]}}, r_a}
                                : {{(ACC_W-P_W){r_prod[P_W-1]}}, r_prod};
    assign w_sum    = {r_acc[ACC_W-1], r_acc} + {w_addend[ACC_W-1], w_addend};
    assign w_ovf    = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    // Clamp direction follows the true sign held in the extra sum bit.
    assign w_store  = (w_ovf && r_s1_sat)
                    ? (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                    : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_ovf  <= 1'b0;
        r_res  <= '0;
        r_rovf <= 1'b0;
      end else if (bus.clr) begin
        r_acc  <= '0;
        r_ovf  <= 1'b0;
      end else if (r_s1_valid) begin
        if (r_s1_last) begin
          r_res  <= w_store;
          r_rovf <= r_ovf | w_ovf;
          r_acc  <= '0;
          r_ovf  <= 1'b0;
        end else begin
          r_acc  <= w_store;
          r_ovf  <= r_ovf | w_ovf;
        end
      end
    end

    assign bus.acc[g*ACC_W +: ACC_W] = r_acc;
    assign bus.res[g*ACC_W +: ACC_W] = r_res;
    assign bus.res_ovf[g]            = r_rovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_vec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_vec_pipe : two instances (zero bypass on/off, ACC_W=17) driven |
// | identically and compared against an integer reference model.          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mac_vec_pipe;
  localparam int LANES = 4;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int ACC_W = 17;
  localparam longint HI  = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint LO  = -(longint'(1) << (ACC_W-1));
  localparam longint MOD = longint'(1) << ACC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_vec_pipe_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) if_b ();
  mac_vec_pipe_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) if_n ();

  mac_vec_pipe #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .ENABLE_ZERO_BYPASS(1))
    u_byp (.clk(clk), .rst(rst), .bus(if_b));
  mac_vec_pipe #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .ENABLE_ZERO_BYPASS(0))
    u_nobyp (.clk(clk), .rst(rst), .bus(if_n));

  logic [LANES*ACC_W-1:0] o_acc  [2];
  logic [LANES*ACC_W-1:0] o_res  [2];
  logic [LANES-1:0]       o_rovf [2];
  logic                   o_rv   [2];
  assign o_acc[0]  = if_b.acc;       assign o_acc[1]  = if_n.acc;
  assign o_res[0]  = if_b.res;       assign o_res[1]  = if_n.res;
  assign o_rovf[0] = if_b.res_ovf;   assign o_rovf[1] = if_n.res_ovf;
  assign o_rv[0]   = if_b.res_valid; assign o_rv[1]   = if_n.res_valid;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: vector-level integer arithmetic plus the one-beat S1 slot.
  longint      m_acc  [LANES];
  longint      m_res  [LANES];
  bit          m_ovf  [LANES];
  bit          m_rovf [LANES];
  bit          exp_rv;
  bit          p_v, p_l, p_m, p_s;
  logic [31:0] p_a, p_b;

  function automatic logic [ACC_W-1:0] tw(input longint x);
    return x[ACC_W-1:0];
  endfunction

  function automatic longint wrapv(input longint x);
    longint t;
    t = (x - LO) % MOD;
    if (t < 0) t += MOD;
    return t + LO;
  endfunction

  function automatic logic [31:0] rops();
    logic [31:0] r;
    r = $urandom;
    for (int i = 0; i < LANES; i++)
      if ($urandom_range(0, 4) == 0) r[i*8 +: 8] = '0;
    return r;
  endfunction

  function automatic logic [31:0] put0(input logic [31:0] x, input logic [7:0] v);
    logic [31:0] y;
    y = x;
    y[7:0] = v;
    return y;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_acc[i] = 0; m_res[i] = 0; m_ovf[i] = 0; m_rovf[i] = 0;
    end
    exp_rv = 0; p_v = 0; p_l = 0; p_m = 0; p_s = 0; p_a = '0; p_b = '0;
  endtask

  task automatic model_edge(input bit iv, il, im, is, ic, input logic [31:0] av, bv);
    exp_rv = 0;
    if (ic) begin
      p_v = 0;
      for (int i = 0; i < LANES; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
    end else begin
      if (p_v) begin
        for (int i = 0; i < LANES; i++) begin
          longint sa, sb, sum, st;
          bit o;
          sa  = longint'($signed(p_a[i*A_W +: A_W]));
          sb  = longint'($signed(p_b[i*B_W +: B_W]));
          sum = m_acc[i] + (p_m ? sa : sa * sb);
          o   = (sum > HI) || (sum < LO);
          st  = !o ? sum : (p_s ? ((sum > HI) ? HI : LO) : wrapv(sum));
          if (p_l) begin
            m_res[i] = st; m_rovf[i] = m_ovf[i] | o; m_acc[i] = 0; m_ovf[i] = 0;
          end else begin
            m_acc[i] = st; m_ovf[i] = m_ovf[i] | o;
          end
        end
        exp_rv = p_l;
      end
      p_v = iv; p_l = il; p_m = im; p_s = is; p_a = av; p_b = bv;
    end
  endtask

  task automatic chk(input string tag, input int d, input int lane,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d lane%0d observed=%0h expected=%0h", tag, d, lane, obs, exp);
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("res_valid", d, 0, 64'(o_rv[d]), 64'(exp_rv));
      for (int i = 0; i < LANES; i++) begin
        chk("acc",     d, i, 64'(o_acc[d][i*ACC_W +: ACC_W]), 64'(tw(m_acc[i])));
        chk("res",     d, i, 64'(o_res[d][i*ACC_W +: ACC_W]), 64'(tw(m_res[i])));
        chk("res_ovf", d, i, 64'(o_rovf[d][i]),               64'(m_rovf[i]));
      end
    end
  endtask

  task automatic chk_res0(input string tag, input longint v, input bit ovf);
    for (int d = 0; d < 2; d++) begin
      chk(tag, d, 0, 64'(o_res[d][ACC_W-1:0]), 64'(tw(v)));
      chk({tag, "_ovf"}, d, 0, 64'(o_rovf[d][0]), 64'(ovf));
    end
  endtask

  task automatic set_in(input bit iv, il, im, is, ic, input logic [31:0] av, bv);
    if_b.in_valid = iv; if_b.last = il; if_b.mode = im; if_b.sat_en = is; if_b.clr = ic;
    if_b.a = av; if_b.b = bv;
    if_n.in_valid = iv; if_n.last = il; if_n.mode = im; if_n.sat_en = is; if_n.clr = ic;
    if_n.a = av; if_n.b = bv;
  endtask

  task automatic beat(input bit iv, il, im, is, ic, input logic [31:0] av, bv);
    set_in(iv, il, im, is, ic, av, bv);
    @(posedge clk);
    model_edge(iv, il, im, is, ic, av, bv);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(0, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, '0, '0);
    model_reset();
    #2 check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic dot product on lane 0: 12 - 10 - 16256
    beat(1, 0, 0, 1, 0, put0(rops(), 8'd3),   put0(rops(), 8'd4));
    beat(1, 0, 0, 1, 0, put0(rops(), 8'hFE),  put0(rops(), 8'd5));
    beat(1, 1, 0, 1, 0, put0(rops(), 8'h7F),  put0(rops(), 8'h80));
    idle(2);
    chk_res0("dot", -16254, 1'b0);

    // Residual mode ignores b; then a zero operand in MAC mode
    beat(1, 0, 1, 0, 0, put0(rops(), 8'hF9), put0(rops(), 8'd99));
    beat(1, 0, 1, 0, 0, put0(rops(), 8'hF9), put0(rops(), 8'd99));
    beat(1, 1, 1, 0, 0, put0(rops(), 8'hF9), put0(rops(), 8'd99));
    idle(2);
    chk_res0("residual", -21, 1'b0);
    beat(1, 0, 0, 0, 0, put0(rops(), 8'd0), put0(rops(), 8'd55));
    beat(1, 1, 0, 0, 0, put0(rops(), 8'd2), put0(rops(), 8'd3));
    idle(2);
    chk_res0("zero_op", 6, 1'b0);

    // Saturating then wrapping accumulation of 127*127 (lane 3: -128*127)
    for (int k = 0; k < 6; k++) beat(1, k == 5, 0, 1, 0, 32'h807F7F7F, 32'h7F7F7F7F);
    beat(1, 0, 0, 1, 0, put0(rops(), 8'd10), put0(rops(), 8'd10));
    beat(1, 1, 0, 1, 0, put0(rops(), 8'd1),  put0(rops(), 8'd1));
    chk_res0("sat", 65535, 1'b1);
    idle(2);
    chk_res0("after_sat", 101, 1'b0);
    for (int k = 0; k < 6; k++) beat(1, k == 5, 0, 0, 0, 32'h807F7F7F, 32'h7F7F7F7F);
    idle(2);
    chk_res0("wrap", -34298, 1'b1);

    // Back-to-back 2-beat vectors
    for (int k = 0; k < 4; k++) beat(1, k[0], 0, 1, 0, rops(), rops());
    idle(2);

    // clr together with a last beat while the previous beat sits in S1
    beat(1, 0, 0, 1, 0, rops(), rops());
    beat(1, 1, 0, 1, 1, rops(), rops());
    idle(2);
    // clr while a last beat sits in S1
    beat(1, 1, 0, 1, 0, rops(), rops());
    beat(0, 0, 0, 0, 1, '0, '0);
    idle(1);
    for (int k = 0; k < 3; k++) beat(1, k == 2, 0, 1, 0, rops(), rops());
    idle(2);

    // Asynchronous reset between edges in the middle of a vector
    beat(1, 0, 0, 1, 0, rops(), rops());
    beat(1, 0, 0, 1, 0, rops(), rops());
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) beat(1, k == 2, 0, 1, 0, rops(), rops());
    idle(2);

    // Random vectors with gaps, mixed modes and both overflow policies
    for (int v = 0; v < 60; v++) begin
      int len;
      bit md, st;
      len = $urandom_range(1, 6);
      md  = ($urandom_range(0, 3) == 0);
      st  = $urandom_range(0, 1);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) beat(0, 0, md, st, 0, rops(), rops());
        beat(1, k == len - 1, md, st, ($urandom_range(0, 40) == 0), rops(), rops());
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mac_vec_pipe.md
# mac_vec_pipe

Parametrised, pipelined signed multiply-accumulate array and the next generation of the single-lane 8x8->32 MAC. It has LANES independent accumulators that share one set of controls. Each lane supports generic operand and accumulator widths, MAC or residual-add mode, and selectable saturation with per-lane sticky overflow. On a `last` beat it snapshots the vector result with a valid pulse and self-clears, so back-to-back dot products need no idle cycles. It sits between the operand fetch/broadcast logic and the requantise/writeback stage of the systolic datapath.

## Interface
- `LANES`, default 4: number of independent MAC lanes.
- `A_W`, default 8: signed width of operand a.
- `B_W`, default 8: signed width of operand b.
- `ACC_W`, default 32: signed accumulator width. Elaboration error unless ACC_W >= A_W+B_W+1.
- `ENABLE_ZERO_BYPASS`, default 1: when set, force multiplier inputs to 0 if either operand is 0 (power only; results are unchanged).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the input beat is valid.
- `a`  in  LANES*A_W  signed operands; lane i is at [i*A_W +: A_W].
- `b`  in  LANES*B_W  signed operands; lane i is at [i*B_W +: B_W].
- `mode`  in  1  0 = MAC (acc += a*b); 1 = residual (acc += a, b ignored).
- `sat_en`  in  1  1 = clamp on overflow; 0 = two's-complement wrap.
- `last`  in  1  with `in_valid`, marks the final beat of a vector.
- `clr`  in  1  synchronous clear of the pipeline, accumulators and flags.
- `acc`  out  LANES*ACC_W  live accumulator values.
- `res`  out  LANES*ACC_W  result snapshot captured on `last`.
- `res_ovf`  out  LANES  per-lane overflow flag for the snapshot vector.
- `res_valid`  out  1  one-cycle pulse when `res`/`res_ovf` update.

## Operation
- **Stage 1 (S1), per lane:**
  - Gate the operands. Zero them when mode=1, or when ENABLE_ZERO_BYPASS=1 and (a==0 or b==0).
  - Register prod = a_g*b_g (A_W+B_W bits, signed) and a sign-extended copy of a.
  - Register in_valid, mode, sat_en and last alongside as s1_valid/s1_mode/s1_sat/s1_last.
- **Stage 2 (S2), per lane, when s1_valid=1:**
  - addend = s1_mode ? sext(a) : sext(prod), extended to ACC_W.
  - Compute sum at ACC_W+1 bits.
  - Overflow occurs when sum[ACC_W] != sum[ACC_W-1].
  - On overflow with s1_sat=1, the stored value clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) according to sum[ACC_W]. With s1_sat=0 the stored value is sum[ACC_W-1:0].
  - On any overflow, set the lane's internal sticky ovf flag.
- **Last beat (s1_valid & s1_last), same edge as its accumulate:**
  - res <= final stored value (including this beat).
  - res_ovf <= ovf | this beat's overflow.
  - res_valid <= 1.
  - acc <= 0 and ovf <= 0, ready for the next vector.
- **Gaps:** when s1_valid=0, acc and ovf hold.
- **clr:**
  - Next edge: s1_valid <= 0, acc <= 0, ovf <= 0.
  - An in_valid beat presented in the clr cycle is dropped.
  - A beat already in S1 is discarded and no res_valid is produced for it.
  - res and res_ovf hold.
- **Lanes:** fully independent arithmetic. Controls are common to all lanes.
- **No backpressure:** a beat is accepted every cycle in_valid=1. The consumer must take `res` within the res_valid cycle.

## Timing
- **Reset:** on rst, asynchronously, acc=0, res=0, res_ovf=0, res_valid=0, and all S1 registers are 0.
- **Latency:** a beat sampled at edge N has its product in S1 after N. It is reflected in acc after edge N+1, i.e. 2 cycles from input to acc.
- **Result timing:** a last beat sampled at edge N gives res_valid=1 during the cycle after edge N+1, with res valid in that cycle. res_valid is high for exactly 1 cycle.
- **Throughput:** 1 beat/cycle per lane. A new vector's first beat may directly follow the previous last beat, with no bubble and no cross-contamination.
- **clr vs in_valid:** clr wins.
- **clr vs an in-flight last:** clr wins. No res_valid, res unchanged.
- **rst vs everything:** rst wins.
- **After saturation:** subsequent beats accumulate from the clamped value. Saturation is not sticky-clamping.

## Test plan
- **Basic dot product:** LANES=4, lane0 a={3,-2,127}, b={4,5,-128}, last on the third beat. Expect lane0 res=12-10-16256=-16254 and res_valid exactly 2 cycles after the last beat, with res_ovf=0.
- **Residual mode and zero operands:** mode=1, a=-7, b=99, 3 beats, then last. Expect res=-21. In MAC mode, a=0 with b=55 adds 0. Results must be identical with ENABLE_ZERO_BYPASS=0 and 1.
- **Saturation:** ACC_W=17, sat_en=1, repeated 127*127 beats. Expect acc to clamp at 65535, res_ovf=1 on last, then the next vector to start at 0 with ovf cleared. With sat_en=0, expect the wrapped value and res_ovf=1.
- **Back-to-back vectors:** two 2-beat vectors with no gap. Expect two res_valid pulses 2 cycles apart, each result correct and independent.
- **clr mid-vector:** assert clr together with a valid last beat while the previous beat is in S1. Expect no res_valid, acc=0, res unchanged, and the next vector correct.
- **Async reset mid-vector:** pulse rst between clock edges. Expect all outputs at 0 immediately, before the next edge, and correct operation afterwards.
